// File: rtl/reorder_queue_pkg.sv
// reorder_queue_pkg
//   Shared definitions for the reorder queue and its neighbours (issue and
//   the functional units): instruction kind encodings and default datapath
//   widths.
package reorder_queue_pkg;

  localparam int DEFAULT_WORD_SIZE = 32;
  localparam int DEFAULT_REG_INDEX = 5;

  typedef enum logic [1:0] {
    KIND_REG    = 2'b00,  // writes a destination register
    KIND_STORE  = 2'b01,  // writes data memory
    KIND_BRANCH = 2'b10,  // may redirect fetch on misprediction
    KIND_NONE   = 2'b11   // retires with no architectural effect
  } kind_e;

  // True when retiring this entry must trigger a full-queue recovery.
  function automatic logic is_flush_branch(input kind_e kind, input logic mispredict);
    return (kind == KIND_BRANCH) && mispredict;
  endfunction

endpackage

// File: rtl/rq_commit_select.sv
// rq_commit_select
//   Combinational lane-eligibility chain for in-order retirement. Lane i
//   looks at the queue entry head+i and retires only when every older lane
//   retired, the entry is valid and ready, it is not a second store this
//   cycle, and no older lane retired a mispredicted branch.
//
// Ports
//   enable          in   retirement allowed this cycle
//   lane_valid      in   per-lane entry valid bit
//   lane_ready      in   per-lane entry ready bit
//   lane_mispredict in   per-lane entry mispredict bit
//   lane_kind       in   per-lane kind, 2 bits per lane
//   retire          out  per-lane retire strobe (contiguous from lane 0)
//   retire_cnt      out  number of lanes retiring
//   flush_fire      out  a mispredicted branch retires this cycle
module rq_commit_select
  import reorder_queue_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int CNT_W        = 4
) (
  input  logic                      enable,
  input  logic [COMMIT_WIDTH-1:0]   lane_valid,
  input  logic [COMMIT_WIDTH-1:0]   lane_ready,
  input  logic [COMMIT_WIDTH-1:0]   lane_mispredict,
  input  logic [2*COMMIT_WIDTH-1:0] lane_kind,
  output logic [COMMIT_WIDTH-1:0]   retire,
  output logic [CNT_W-1:0]          retire_cnt,
  output logic                      flush_fire
);

  always_comb begin
    logic  blocked;
    logic  store_taken;
    kind_e kind;
    retire      = '0;
    retire_cnt  = '0;
    flush_fire  = 1'b0;
    blocked     = !enable;
    store_taken = 1'b0;
    kind        = KIND_NONE;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      kind = kind_e'(lane_kind[2*i +: 2]);
      // Only one memory write port: a second store waits for next cycle,
      // and everything younger than it must wait too to keep order.
      if (!blocked && lane_valid[i] && lane_ready[i] &&
          !((kind == KIND_STORE) && store_taken)) begin
        retire[i]  = 1'b1;
        retire_cnt = retire_cnt + CNT_W'(1);
        if (kind == KIND_STORE) begin
          store_taken = 1'b1;
        end
        if (is_flush_branch(kind, lane_mispredict[i])) begin
          flush_fire = 1'b1;
          blocked    = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reorder_queue.sv
// reorder_queue
//   Circular reorder buffer. Allocates entries in program order, accepts
//   results from CDB_PORTS completion ports, and retires up to COMMIT_WIDTH
//   ready entries per cycle to the register file and data memory. A retiring
//   mispredicted branch empties the whole queue and raises a one-cycle flush
//   with the branch target as redirect PC.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   alloc_valid/ready/pc/rdest/kind  front-end allocation handshake
//   alloc_tag                        tag assigned to the presented instruction
//   cdb_valid/tag/data/addr/mispredict  completion ports (higher index wins)
//   rd_tag, rd_ready, rd_data        two operand lookups with CDB bypass
//   we_reg, ws_reg, wd_reg           register writes, one per commit lane
//   we_mem, ws_mem, wd_mem           single store commit
//   flush, flush_pc                  recovery pulse and redirect target
//   count                            occupied entries
module reorder_queue
  import reorder_queue_pkg::*;
#(
  parameter int RB_SIZE      = 8,
  parameter int RB_INDEX     = $clog2(RB_SIZE),
  parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
  parameter int REG_INDEX    = DEFAULT_REG_INDEX,
  parameter int CDB_PORTS    = 2,
  parameter int COMMIT_WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alloc_valid,
  output logic                              alloc_ready,
  input  logic [WORD_SIZE-1:0]              alloc_pc,
  input  logic [REG_INDEX-1:0]              alloc_rdest,
  input  logic [1:0]                        alloc_kind,
  output logic [RB_INDEX-1:0]               alloc_tag,
  input  logic [CDB_PORTS-1:0]              cdb_valid,
  input  logic [CDB_PORTS*RB_INDEX-1:0]     cdb_tag,
  input  logic [CDB_PORTS*WORD_SIZE-1:0]    cdb_data,
  input  logic [CDB_PORTS*WORD_SIZE-1:0]    cdb_addr,
  input  logic [CDB_PORTS-1:0]              cdb_mispredict,
  input  logic [2*RB_INDEX-1:0]             rd_tag,
  output logic [1:0]                        rd_ready,
  output logic [2*WORD_SIZE-1:0]            rd_data,
  output logic [COMMIT_WIDTH-1:0]           we_reg,
  output logic [COMMIT_WIDTH*REG_INDEX-1:0] ws_reg,
  output logic [COMMIT_WIDTH*WORD_SIZE-1:0] wd_reg,
  output logic                              we_mem,
  output logic [WORD_SIZE-1:0]              ws_mem,
  output logic [WORD_SIZE-1:0]              wd_mem,
  output logic                              flush,
  output logic [WORD_SIZE-1:0]              flush_pc,
  output logic [RB_INDEX:0]                 count
);

  localparam int CNT_W = RB_INDEX + 1;

  // Per-entry state
  logic [RB_SIZE-1:0]   valid_q, valid_d;
  logic [RB_SIZE-1:0]   ready_q, ready_d;
  logic [RB_SIZE-1:0]   mispredict_q, mispredict_d;
  kind_e                kind_q  [RB_SIZE];
  kind_e                kind_d  [RB_SIZE];
  logic [REG_INDEX-1:0] rdest_q [RB_SIZE];
  logic [REG_INDEX-1:0] rdest_d [RB_SIZE];
  logic [WORD_SIZE-1:0] pc_q    [RB_SIZE];
  logic [WORD_SIZE-1:0] pc_d    [RB_SIZE];
  logic [WORD_SIZE-1:0] data_q  [RB_SIZE];
  logic [WORD_SIZE-1:0] data_d  [RB_SIZE];
  logic [WORD_SIZE-1:0] addr_q  [RB_SIZE];
  logic [WORD_SIZE-1:0] addr_d  [RB_SIZE];

  // Pointers and recovery state
  logic [RB_INDEX-1:0]  head_q, head_d;
  logic [RB_INDEX-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 flush_q, flush_d;
  logic [WORD_SIZE-1:0] flush_pc_q, flush_pc_d;

  // Commit lane view of the head entries
  logic [COMMIT_WIDTH-1:0]   lane_valid;
  logic [COMMIT_WIDTH-1:0]   lane_ready;
  logic [COMMIT_WIDTH-1:0]   lane_mispredict;
  logic [2*COMMIT_WIDTH-1:0] lane_kind;
  logic [COMMIT_WIDTH-1:0]   retire;
  logic [CNT_W-1:0]          retire_cnt;
  logic                      flush_fire;
  logic                      alloc_fire;

  // count never exceeds RB_SIZE = 2**RB_INDEX, so its top bit means "full".
  assign alloc_ready = !count_q[RB_INDEX] && !flush_q;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail_q;
  assign count       = count_q;
  assign flush       = flush_q;
  assign flush_pc    = flush_pc_q;

  // Gather the entries at head+i for each commit lane (indices wrap).
  always_comb begin
    logic [RB_INDEX-1:0] idx;
    lane_valid      = '0;
    lane_ready      = '0;
    lane_mispredict = '0;
    lane_kind       = '0;
    idx             = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      idx                  = head_q + RB_INDEX'(i);
      lane_valid[i]        = valid_q[idx];
      lane_ready[i]        = ready_q[idx];
      lane_mispredict[i]   = mispredict_q[idx];
      lane_kind[2*i +: 2]  = kind_q[idx];
    end
  end

  rq_commit_select #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .CNT_W        (CNT_W)
  ) u_commit_select (
    .enable          (!reset),
    .lane_valid      (lane_valid),
    .lane_ready      (lane_ready),
    .lane_mispredict (lane_mispredict),
    .lane_kind       (lane_kind),
    .retire          (retire),
    .retire_cnt      (retire_cnt),
    .flush_fire      (flush_fire)
  );

  // Drive the register/memory write ports from the retiring lanes.
  always_comb begin
    logic [RB_INDEX-1:0] idx;
    we_reg = '0;
    ws_reg = '0;
    wd_reg = '0;
    we_mem = 1'b0;
    ws_mem = '0;
    wd_mem = '0;
    idx    = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      idx = head_q + RB_INDEX'(i);
      if (retire[i]) begin
        case (kind_q[idx])
          KIND_REG: begin
            we_reg[i]                        = 1'b1;
            ws_reg[i*REG_INDEX +: REG_INDEX] = rdest_q[idx];
            wd_reg[i*WORD_SIZE +: WORD_SIZE] = data_q[idx];
          end
          KIND_STORE: begin
            we_mem = 1'b1;
            ws_mem = addr_q[idx];
            wd_mem = data_q[idx];
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Operand lookup: stored result, overridden by a same-cycle CDB hit
  // (highest port index wins, matching write priority).
  always_comb begin
    logic [RB_INDEX-1:0]  t;
    logic                 hit;
    logic [WORD_SIZE-1:0] val;
    rd_ready = '0;
    rd_data  = '0;
    t        = '0;
    hit      = 1'b0;
    val      = '0;
    for (int j = 0; j < 2; j++) begin
      t   = rd_tag[j*RB_INDEX +: RB_INDEX];
      hit = ready_q[t];
      val = data_q[t];
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (cdb_valid[p] && (cdb_tag[p*RB_INDEX +: RB_INDEX] == t)) begin
          hit = 1'b1;
          val = cdb_data[p*WORD_SIZE +: WORD_SIZE];
        end
      end
      rd_ready[j]                       = valid_q[t] && hit;
      rd_data[j*WORD_SIZE +: WORD_SIZE] = val;
    end
  end

  // Next-state: completions, retirement, allocation, then flush override.
  always_comb begin
    logic [RB_INDEX-1:0] t;
    logic [RB_INDEX-1:0] idx;
    valid_d      = valid_q;
    ready_d      = ready_q;
    mispredict_d = mispredict_q;
    kind_d       = kind_q;
    rdest_d      = rdest_q;
    pc_d         = pc_q;
    data_d       = data_q;
    addr_d       = addr_q;
    head_d       = head_q + retire_cnt[RB_INDEX-1:0];
    tail_d       = tail_q;
    count_d      = count_q + CNT_W'(alloc_fire) - retire_cnt;
    flush_d      = flush_fire;
    flush_pc_d   = flush_pc_q;
    t            = '0;
    idx          = '0;

    // Later ports overwrite earlier ones on a shared tag.
    for (int p = 0; p < CDB_PORTS; p++) begin
      t = cdb_tag[p*RB_INDEX +: RB_INDEX];
      if (cdb_valid[p] && valid_q[t]) begin
        ready_d[t]      = 1'b1;
        data_d[t]       = cdb_data[p*WORD_SIZE +: WORD_SIZE];
        addr_d[t]       = cdb_addr[p*WORD_SIZE +: WORD_SIZE];
        mispredict_d[t] = cdb_mispredict[p];
      end
    end

    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      idx = head_q + RB_INDEX'(i);
      if (retire[i]) begin
        valid_d[idx] = 1'b0;
        ready_d[idx] = 1'b0;
        if (is_flush_branch(kind_q[idx], mispredict_q[idx])) begin
          flush_pc_d = data_q[idx];
        end
      end
    end

    // The tail slot is never valid when allocation is allowed, so this
    // cannot collide with a completion above.
    if (alloc_fire) begin
      valid_d[tail_q]      = 1'b1;
      ready_d[tail_q]      = 1'b0;
      mispredict_d[tail_q] = 1'b0;
      kind_d[tail_q]       = kind_e'(alloc_kind);
      rdest_d[tail_q]      = alloc_rdest;
      pc_d[tail_q]         = alloc_pc;
      data_d[tail_q]       = '0;
      addr_d[tail_q]       = '0;
      tail_d               = tail_q + RB_INDEX'(1);
    end

    // Recovery discards everything, including an allocation at this edge.
    if (flush_fire) begin
      valid_d = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= '0;
      ready_q      <= '0;
      mispredict_q <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      flush_q      <= 1'b0;
      flush_pc_q   <= '0;
      for (int e = 0; e < RB_SIZE; e++) begin
        kind_q[e]  <= KIND_NONE;
        rdest_q[e] <= '0;
        pc_q[e]    <= '0;
        data_q[e]  <= '0;
        addr_q[e]  <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      ready_q      <= ready_d;
      mispredict_q <= mispredict_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      flush_q      <= flush_d;
      flush_pc_q   <= flush_pc_d;
      kind_q       <= kind_d;
      rdest_q      <= rdest_d;
      pc_q         <= pc_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
    end
  end

endmodule

// File: tb/tb_reorder_queue.sv
// tb_reorder_queue
//   Directed bench for reorder_queue with default parameters (8 entries,
//   2 CDB ports, 2 commit lanes). Inputs change 1 time unit after the rising
//   edge; outputs are compared 1 time unit later, well away from the edge.
module tb_reorder_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [31:0] alloc_pc;
  logic [4:0]  alloc_rdest;
  logic [1:0]  alloc_kind;
  logic [2:0]  alloc_tag;
  logic [1:0]  cdb_valid;
  logic [5:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic [63:0] cdb_addr;
  logic [1:0]  cdb_mispredict;
  logic [5:0]  rd_tag;
  logic [1:0]  rd_ready;
  logic [63:0] rd_data;
  logic [1:0]  we_reg;
  logic [9:0]  ws_reg;
  logic [63:0] wd_reg;
  logic        we_mem;
  logic [31:0] ws_mem;
  logic [31:0] wd_mem;
  logic        flush;
  logic [31:0] flush_pc;
  logic [3:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reorder_queue dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_pc       (alloc_pc),
    .alloc_rdest    (alloc_rdest),
    .alloc_kind     (alloc_kind),
    .alloc_tag      (alloc_tag),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .cdb_addr       (cdb_addr),
    .cdb_mispredict (cdb_mispredict),
    .rd_tag         (rd_tag),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .we_reg         (we_reg),
    .ws_reg         (ws_reg),
    .wd_reg         (wd_reg),
    .we_mem         (we_mem),
    .ws_mem         (ws_mem),
    .wd_mem         (wd_mem),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .count          (count)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    alloc_valid    = 1'b0;
    alloc_pc       = 32'h0;
    alloc_rdest    = 5'd0;
    alloc_kind     = 2'b00;
    cdb_valid      = 2'b00;
    cdb_tag        = 6'd0;
    cdb_data       = 64'h0;
    cdb_addr       = 64'h0;
    cdb_mispredict = 2'b00;
  endtask

  task automatic set_alloc(input logic [31:0] pc, input logic [4:0] rd, input logic [1:0] kind);
    alloc_valid = 1'b1;
    alloc_pc    = pc;
    alloc_rdest = rd;
    alloc_kind  = kind;
  endtask

  task automatic set_cdb(input int p, input logic [2:0] t, input logic [31:0] d,
                         input logic [31:0] a, input logic m);
    cdb_valid[p]        = 1'b1;
    cdb_tag[p*3 +: 3]   = t;
    cdb_data[p*32 +: 32] = d;
    cdb_addr[p*32 +: 32] = a;
    cdb_mispredict[p]   = m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  tag_a, tag_b;
    logic [4:0]  rd_a, rd_b;
    logic [31:0] d_a, d_b;

    clear_inputs();
    rd_tag = 6'd0;
    reset  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();

    // ---- reset state ----
    check_eq("rst_count",       count,       64'd0);
    check_eq("rst_alloc_ready", alloc_ready, 64'd1);
    check_eq("rst_alloc_tag",   alloc_tag,   64'd0);
    check_eq("rst_we_reg",      we_reg,      64'd0);
    check_eq("rst_we_mem",      we_mem,      64'd0);
    check_eq("rst_flush",       flush,       64'd0);
    check_eq("rst_flush_pc",    flush_pc,    64'd0);

    // ---- fill with 8 reg-writes, rdest = tag+1 ----
    for (int i = 0; i < 8; i++) begin
      set_alloc(32'h100 + 32'(4*i), 5'(i + 1), 2'b00);
      settle();
      check_eq("fill_tag", alloc_tag, 64'(i));
      check_eq("fill_ready", alloc_ready, 64'd1);
      tick();
    end
    clear_inputs();
    settle();
    check_eq("full_count", count, 64'd8);
    check_eq("full_alloc_ready", alloc_ready, 64'd0);

    // ---- complete tags 0,1 on ports 0/1 ----
    set_cdb(0, 3'd0, 32'hA0, 32'h0, 1'b0);
    set_cdb(1, 3'd1, 32'hA1, 32'h0, 1'b0);
    settle();
    check_eq("cdb_no_same_cycle_commit", we_reg, 64'd0);
    tick();
    clear_inputs();
    settle();
    check_eq("dual_we_reg", we_reg, 64'd3);
    check_eq("dual_ws_reg", ws_reg, 64'((2 << 5) | 1));
    check_eq("dual_wd_reg", wd_reg, 64'h000000A1_000000A0);
    check_eq("full_commit_no_alloc", alloc_ready, 64'd0);
    tick();
    check_eq("dual_count", count, 64'd6);
    check_eq("freed_alloc_ready", alloc_ready, 64'd1);

    // ---- out-of-order completion: tag 3 then tag 2 ----
    set_cdb(0, 3'd3, 32'hB3, 32'h0, 1'b0);
    tick();
    clear_inputs();
    settle();
    check_eq("ooo_blocked", we_reg, 64'd0);
    check_eq("ooo_count", count, 64'd6);
    set_cdb(1, 3'd2, 32'hB2, 32'h0, 1'b0);
    tick();
    clear_inputs();
    settle();
    check_eq("ooo_we_reg", we_reg, 64'd3);
    check_eq("ooo_ws_reg", ws_reg, 64'((4 << 5) | 3));
    check_eq("ooo_wd_reg", wd_reg, 64'h000000B3_000000B2);
    tick();
    check_eq("ooo_count_after", count, 64'd4);

    // ---- same-tag dual CDB: port 1 wins for bypass and write ----
    set_cdb(0, 3'd4, 32'd5, 32'h0, 1'b0);
    set_cdb(1, 3'd4, 32'd9, 32'h0, 1'b0);
    rd_tag = {3'd5, 3'd4};
    settle();
    check_eq("bypass_ready", rd_ready, 64'b01);
    check_eq("bypass_data", rd_data[31:0], 64'd9);
    tick();
    clear_inputs();
    settle();
    check_eq("prio_we_reg", we_reg, 64'd1);
    check_eq("prio_ws_reg", ws_reg, 64'd5);
    check_eq("prio_wd_reg", wd_reg, 64'd9);
    check_eq("stored_rd_ready", rd_ready, 64'b01);
    check_eq("stored_rd_data", rd_data[31:0], 64'd9);
    tick();
    check_eq("prio_count", count, 64'd3);

    // ---- drain tags 5,6,7 ----
    set_cdb(0, 3'd5, 32'hC5, 32'h0, 1'b0);
    set_cdb(1, 3'd6, 32'hC6, 32'h0, 1'b0);
    tick();
    clear_inputs();
    settle();
    check_eq("drain_we_reg", we_reg, 64'd3);
    check_eq("drain_ws_reg", ws_reg, 64'((7 << 5) | 6));
    set_cdb(0, 3'd7, 32'hC7, 32'h0, 1'b0);
    tick();
    clear_inputs();
    settle();
    check_eq("drain_count", count, 64'd1);
    check_eq("drain_last_ws", ws_reg, 64'd8);
    check_eq("drain_last_wd", wd_reg, 64'hC7);
    tick();
    check_eq("drain_empty", count, 64'd0);
    check_eq("drain_tail_wrapped", alloc_tag, 64'd0);

    // ---- two stores at head: one per cycle ----
    set_alloc(32'h300, 5'd0, 2'b01);
    tick();
    set_alloc(32'h304, 5'd0, 2'b01);
    tick();
    clear_inputs();
    set_cdb(0, 3'd0, 32'hD0, 32'h1000, 1'b0);
    set_cdb(1, 3'd1, 32'hD1, 32'h1004, 1'b0);
    tick();
    clear_inputs();
    settle();
    check_eq("st1_we_mem", we_mem, 64'd1);
    check_eq("st1_ws_mem", ws_mem, 64'h1000);
    check_eq("st1_wd_mem", wd_mem, 64'hD0);
    check_eq("st1_we_reg", we_reg, 64'd0);
    tick();
    check_eq("st2_count", count, 64'd1);
    check_eq("st2_we_mem", we_mem, 64'd1);
    check_eq("st2_ws_mem", ws_mem, 64'h1004);
    check_eq("st2_wd_mem", wd_mem, 64'hD1);
    tick();
    check_eq("st_done_we_mem", we_mem, 64'd0);
    check_eq("st_done_count", count, 64'd0);

    // ---- mispredicted branch at tag 2 with younger ready entries ----
    set_alloc(32'h200, 5'd0, 2'b10);
    settle();
    check_eq("br_tag", alloc_tag, 64'd2);
    tick();
    set_alloc(32'h204, 5'd9, 2'b00);
    tick();
    set_alloc(32'h208, 5'd10, 2'b00);
    tick();
    clear_inputs();
    set_cdb(0, 3'd3, 32'hE3, 32'h0, 1'b0);
    set_cdb(1, 3'd4, 32'hE4, 32'h0, 1'b0);
    tick();
    clear_inputs();
    settle();
    check_eq("br_wait_we_reg", we_reg, 64'd0);
    check_eq("br_wait_count", count, 64'd3);
    set_cdb(0, 3'd2, 32'h40, 32'h0, 1'b1);
    tick();
    clear_inputs();
    settle();
    check_eq("br_cut_we_reg", we_reg, 64'd0);
    check_eq("br_cut_flush", flush, 64'd0);
    check_eq("br_cut_count", count, 64'd3);
    // allocation presented at the flushing edge must be discarded
    set_alloc(32'h20C, 5'd12, 2'b00);
    tick();
    clear_inputs();
    set_cdb(0, 3'd3, 32'hEE, 32'h0, 1'b0);
    settle();
    check_eq("flush_pulse", flush, 64'd1);
    check_eq("flush_pc", flush_pc, 64'h40);
    check_eq("flush_count", count, 64'd0);
    check_eq("flush_alloc_ready", alloc_ready, 64'd0);
    check_eq("flush_alloc_tag", alloc_tag, 64'd0);
    check_eq("flush_we_reg", we_reg, 64'd0);
    tick();
    clear_inputs();
    rd_tag = {3'd0, 3'd3};
    settle();
    check_eq("flush_end", flush, 64'd0);
    check_eq("post_flush_ready", alloc_ready, 64'd1);
    check_eq("late_cdb_ignored", rd_ready[0], 64'd0);
    set_alloc(32'h400, 5'd11, 2'b00);
    tick();
    clear_inputs();
    settle();
    check_eq("post_flush_count", count, 64'd1);
    check_eq("post_flush_tag", alloc_tag, 64'd1);
    set_cdb(1, 3'd0, 32'h77, 32'h0, 1'b0);
    tick();
    clear_inputs();
    settle();
    check_eq("post_flush_we_reg", we_reg, 64'd1);
    check_eq("post_flush_ws_reg", ws_reg, 64'd11);
    check_eq("post_flush_wd_reg", wd_reg, 64'h77);
    tick();

    // ---- 20 alloc/commit rounds, two per round, pointers wrap ----
    for (int r = 0; r < 20; r++) begin
      tag_a = 3'((1 + 2*r) % 8);
      tag_b = 3'((2 + 2*r) % 8);
      rd_a  = 5'(((2*r) % 30) + 1);
      rd_b  = 5'(((2*r + 1) % 30) + 1);
      d_a   = 32'h5000 + 32'(2*r);
      d_b   = 32'h5000 + 32'(2*r + 1);
      set_alloc(32'h800 + 32'(8*r), rd_a, 2'b00);
      settle();
      check_eq("wrap_tag_a", alloc_tag, 64'(tag_a));
      tick();
      set_alloc(32'h804 + 32'(8*r), rd_b, 2'b00);
      settle();
      check_eq("wrap_tag_b", alloc_tag, 64'(tag_b));
      tick();
      clear_inputs();
      set_cdb(0, tag_a, d_a, 32'h0, 1'b0);
      set_cdb(1, tag_b, d_b, 32'h0, 1'b0);
      tick();
      clear_inputs();
      settle();
      check_eq("wrap_we_reg", we_reg, 64'd3);
      check_eq("wrap_ws_reg", ws_reg, 64'({rd_b, rd_a}));
      check_eq("wrap_wd_reg", wd_reg, {d_b, d_a});
      tick();
      check_eq("wrap_count", count, 64'd0);
    end

    // ---- reset mid-operation discards entries ----
    set_alloc(32'h900, 5'd3, 2'b00);
    tick();
    clear_inputs();
    set_cdb(0, 3'd1, 32'h99, 32'h0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_inputs();
    settle();
    check_eq("midrst_count", count, 64'd0);
    check_eq("midrst_alloc_tag", alloc_tag, 64'd0);
    check_eq("midrst_we_reg", we_reg, 64'd0);
    check_eq("midrst_flush", flush, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_queue.md
# reorder_queue

Parametrised successor to the single-issue reorder buffer. It allocates entries in program order from the front end, accepts results from multiple CDB completion ports, and retires up to COMMIT_WIDTH ready entries per cycle to the register file and data memory. Branch mispredictions are recovered at commit by flushing the whole queue. It sits between the fetch/issue stage and the architectural register file / data memory.

## Interface
- RB_SIZE, 8: entries; power of two, ≥4
- RB_INDEX, $clog2(RB_SIZE): tag width
- WORD_SIZE, 32: data/address/PC width
- REG_INDEX, 5: register number width
- CDB_PORTS, 2: completion ports
- COMMIT_WIDTH, 2: max retirements per cycle (1..4)

Ports. One clock; reset is synchronous and active-high. Ports are `clk` and `reset`.
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- alloc_valid  in  1  front end presents an instruction
- alloc_ready  out  1  space available; transfer when valid&&ready
- alloc_pc  in  WORD_SIZE  instruction PC
- alloc_rdest  in  REG_INDEX  destination register
- alloc_kind  in  2  00 reg-write, 01 store, 10 branch, 11 no-effect
- alloc_tag  out  RB_INDEX  tag given to the presented instruction (= tail)
- cdb_valid  in  CDB_PORTS  per-port result strobe
- cdb_tag  in  CDB_PORTS*RB_INDEX  entry being completed
- cdb_data  in  CDB_PORTS*WORD_SIZE  result; store data; branch target
- cdb_addr  in  CDB_PORTS*WORD_SIZE  store address
- cdb_mispredict  in  CDB_PORTS  branch resolved against prediction
- rd_tag  in  2*RB_INDEX  operand lookup tags (j, k)
- rd_ready  out  2  entry complete (including same-cycle CDB bypass)
- rd_data  out  2*WORD_SIZE  entry value (bypassed)
- we_reg  out  COMMIT_WIDTH  register write strobe per lane
- ws_reg  out  COMMIT_WIDTH*REG_INDEX  register number per lane
- wd_reg  out  COMMIT_WIDTH*WORD_SIZE  register data per lane
- we_mem  out  1  store commit strobe
- ws_mem  out  WORD_SIZE  store address
- wd_mem  out  WORD_SIZE  store data
- flush  out  1  one-cycle recovery pulse
- flush_pc  out  WORD_SIZE  redirect target
- count  out  RB_INDEX+1  occupied entries

## Operation
- Per-entry state: valid, ready, kind, rdest, pc, data, addr, mispredict. Pointers: head, tail, count.
- Allocate: on valid&&ready, write the entry at tail with ready=0, then tail+1 mod RB_SIZE.
- Complete: each port with cdb_valid writes data, addr, and mispredict into entry cdb_tag and sets ready. Writes to non-valid entries are ignored. If two ports hit the same tag, the higher port index wins.
- Commit lanes i=0..COMMIT_WIDTH-1 examine head+i. Lane i retires only if all of the following hold:
  - lanes <i retired
  - entry is valid and ready
  - entry is not a second store this cycle
  - no earlier lane retired a mispredicted branch
- Per retiring kind:
  - reg-write drives we_reg[i]/ws_reg/wd_reg
  - store drives we_mem/ws_mem/wd_mem
  - branch/no-effect produce no write
- A retiring mispredicted branch is the last retirement that cycle. At that edge all valid bits clear and head=tail=count=0. The next cycle has flush=1 and flush_pc=its data.
- count_next = count + alloc_fire − retired. An allocation at a flushing edge is discarded.

## Timing
- Commit outputs are combinational from head entries. State updates at the rising edge.
- CDB→commit latency is 1 cycle; CDB writes at edge N are committable in cycle N+1.
- rd_ready/rd_data bypass the CDB combinationally. Port priority is the same as for writes.
- alloc_ready = (count<RB_SIZE) && !flush. Full-plus-commit in the same cycle does not allow allocation; the freed slot becomes visible next cycle.
- Wrap-around: head and tail roll over RB_SIZE-1→0, and lane indices also roll over.
- Reset outputs, state, and in-flight results:
  - all we_* = 0, flush = 0, flush_pc = 0, count = 0, alloc_ready = 1, alloc_tag = 0
  - head = tail = 0, all entries invalid
  - reset mid-operation discards every entry and any pending flush

## Structure
- Shared package holds: kind encodings (KIND_REG, KIND_STORE, KIND_BRANCH, KIND_NONE) and the default WORD_SIZE/REG_INDEX constants. These are reused by issue and the functional units.
- One sub-module, rq_commit_select, holds the combinational lane-eligibility chain (head entries → retire vector, store/mispredict cut).

## Test plan
- Reset, then allocate 8 reg-writes with tags 0..7 → alloc_ready=0 at count=8. Complete tags 0,1 on ports 0/1 → the next cycle we_reg=11 with the correct ws/wd, and count=6.
- Complete tag 1 before tag 0 → nothing retires until tag 0 is ready. Then both retire in one cycle, in order.
- Two ready stores at head → we_mem on the first only; the second retires the following cycle.
- Branch at tag 2 completes with mispredict and data=0x40, younger entries ready → retire up to tag 2. Next cycle flush=1, flush_pc=0x40, count=0. A late CDB to tag 3 is ignored.
- Run 20 alloc/commit rounds with RB_SIZE=8 → pointers wrap and retirement order equals allocation order.
- Same-cycle CDB ports 0 and 1 to tag 4 with data 5/9 → rd_data(tag 4) bypasses 9 and retires 9.
